// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side drain stage placed directly after a synchronous FIFO. It pops
// words through the FIFO read port, absorbs the FIFO's one-cycle read latency,
// and re-times the words into a valid/ready stream through a 3-entry skid
// buffer. The stream is grouped into fixed-length bursts; out_last flags the
// final word of every burst. One word per cycle is sustained, and no word is
// lost under downstream backpressure.
//
// Parameters
//   WIDTH      data word width (must match the upstream FIFO)
//   BURST_LEN  words per burst, >= 1
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous reset, active-low
//   enable       in   permission to start or continue bursts
//   fifo_empty   in   FIFO empty flag
//   fifo_r_en    out  FIFO pop request (never high while fifo_empty)
//   fifo_dout    in   FIFO read data, valid the cycle after an accepted pop
//   out_valid    out  output word valid
//   out_ready    in   downstream accept
//   out_data     out  output word (head of the skid buffer)
//   out_last     out  last word of a burst, qualified by out_valid
//   busy         out  FSM is not idle
//   bursts_done  out  count of completed output bursts, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_r_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      bursts_done
);

  // Burst index counters need at least one bit, even for BURST_LEN = 1.
  localparam int                IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BURST_LEN - 1);
  localparam int                DEPTH    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,       state_d;
  logic [1:0]         occ_q,         occ_d;
  logic               inflight_q,    inflight_d;
  logic [IDX_W-1:0]   pop_idx_q,     pop_idx_d;
  logic [IDX_W-1:0]   out_idx_q,     out_idx_d;
  logic [1:0]         head_q,        head_d;
  logic [1:0]         tail_q,        tail_d;
  logic [WIDTH-1:0]   buf_q [DEPTH];
  logic [WIDTH-1:0]   buf_d [DEPTH];
  logic [15:0]        bursts_done_q, bursts_done_d;

  // Per-cycle events
  logic capture;   // word from the FIFO lands in the skid buffer this cycle
  logic beat;      // output word accepted downstream this cycle
  logic credit_ok; // room for one more word, counting the one in flight

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Output stream and pop request
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first) so that no latch is inferred.
  always_comb begin
    out_valid = (occ_q != 2'd0);
    out_data  = buf_q[head_q];
    out_last  = out_valid && (out_idx_q == IDX_LAST);
    beat      = out_valid && out_ready;
    capture   = inflight_q;
    busy      = (state_q != ST_IDLE);

    // A word still travelling out of the FIFO already owns a buffer slot. The
    // same-cycle output beat is deliberately not credited, which keeps the
    // pop decision independent of out_ready (no combinational ready path to
    // the FIFO).
    credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
    fifo_r_en = (state_q == ST_BURST) && !fifo_empty && credit_ok;
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: circular, head = oldest word, tail = next free slot
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;

    if (capture) begin
      buf_d[tail_q] = fifo_dout;
      tail_d        = next_ptr(tail_q);
    end
    if (beat) begin
      head_d = next_ptr(head_q);
    end

    // Simultaneous capture and beat leave the occupancy unchanged. The credit
    // check on popping guarantees capture never overfills the buffer.
    unique case ({capture, beat})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // The FIFO presents popped data exactly one cycle later.
    inflight_d = fifo_r_en;
  end

  // ---------------------------------------------------------------------------
  // Pop-side FSM: counts pops per burst and decides whether to continue
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pop_idx_d = pop_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d   = ST_BURST;
          pop_idx_d = '0;
        end
      end

      ST_BURST: begin
        // An empty FIFO simply stalls the burst; once started, a burst always
        // pops all BURST_LEN words even if enable falls part way through.
        if (fifo_r_en) begin
          if (pop_idx_q == IDX_LAST) begin
            pop_idx_d = '0;
            if (!enable) begin
              state_d = ST_FLUSH;
            end
          end else begin
            pop_idx_d = pop_idx_q + IDX_W'(1);
          end
        end
      end

      ST_FLUSH: begin
        // Leave only after every popped word has been handed downstream.
        if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pop_idx_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Emission-side counters
  // ---------------------------------------------------------------------------
  always_comb begin
    out_idx_d     = out_idx_q;
    bursts_done_d = bursts_done_q;

    if (beat) begin
      out_idx_d = (out_idx_q == IDX_LAST) ? '0 : out_idx_q + IDX_W'(1);
      if (out_last) begin
        bursts_done_d = bursts_done_q + 16'd1;
      end
    end

    bursts_done = bursts_done_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      pop_idx_q     <= '0;
      out_idx_q     <= '0;
      head_q        <= 2'd0;
      tail_q        <= 2'd0;
      bursts_done_q <= 16'd0;
      // NOTE: the buffer storage is reset too; out_data shows the head entry
      // and must read as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      pop_idx_q     <= pop_idx_d;
      out_idx_q     <= out_idx_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      bursts_done_q <= bursts_done_d;
      buf_q         <= buf_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Self-checking bench for fifo_burst_reader. The upstream FIFO is modelled as a
// queue that serves a pop one cycle after the request. A scoreboard holds the
// words popped but not yet delivered: every output beat must match its head,
// out_last must fall on every BURST_LEN-th beat, a pop may only be issued when
// fewer than 3 words are outstanding, and a stalled output must hold.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int WIDTH = 16;
  localparam int BL    = 4;

  logic             clk        = 1'b0;
  logic             rst        = 1'b0;
  logic             enable     = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout  = '0;
  logic             out_ready  = 1'b0;
  logic             fifo_r_en;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [15:0]      bursts_done;

  fifo_burst_reader #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_r_en   (fifo_r_en),
    .fifo_dout   (fifo_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .bursts_done (bursts_done)
  );

  always #5 clk = ~clk;

  // Pre-edge snapshot of the handshake signals, taken 1 time unit before each
  // rising edge so that mid-cycle events (such as reset) are seen as the DUT
  // sees them at the edge.
  logic             s_ren = 1'b0, s_empty = 1'b1, s_valid = 1'b0, s_ready = 1'b0, s_last = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  always begin
    @(negedge clk);
    #4;
    s_ren   = fifo_r_en;
    s_empty = fifo_empty;
    s_valid = out_valid;
    s_ready = out_ready;
    s_data  = out_data;
    s_last  = out_last;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // FIFO model and scoreboard
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] beat_data[$];
  logic             beat_last[$];
  int               pop_cnt, beat_cnt;
  logic             p_valid, p_ready, p_last;
  logic [WIDTH-1:0] p_data;

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic mon_clear();
    sb_q.delete();
    beat_data.delete();
    beat_last.delete();
    pop_cnt  = 0;
    beat_cnt = 0;
    p_valid  = 1'b0;
    p_ready  = 1'b0;
    p_last   = 1'b0;
    p_data   = '0;
  endtask

  // Advance one clock. Entered and left at negedge+1.
  task automatic tick();
    logic [WIDTH-1:0] w;
    logic             pop;
    @(posedge clk);
    #1;
    pop = s_ren && !s_empty;
    if (s_ren) check("ren_while_empty", 32'(s_empty), 32'd0);
    // Outstanding words (popped, not yet delivered before this cycle) < 3.
    if (pop) check("pop_credit", 32'(sb_q.size()), 32'(sb_q.size() < 3 ? sb_q.size() : 2));
    if (s_valid && s_ready) begin
      check("beat_has_word", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        w = sb_q.pop_front();
        check("beat_data", 32'(s_data), 32'(w));
        check("beat_last", 32'(s_last), 32'((beat_cnt % BL) == BL - 1));
        beat_data.push_back(s_data);
        beat_last.push_back(s_last);
        beat_cnt++;
      end
    end
    if (p_valid && !p_ready) begin
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_data",  32'(s_data),  32'(p_data));
      check("stall_last",  32'(s_last),  32'(p_last));
    end
    p_valid = s_valid;
    p_ready = s_ready;
    p_data  = s_data;
    p_last  = s_last;
    if (pop) begin
      w         = fifo_q.pop_front();
      fifo_dout = w;
      sb_q.push_back(w);
      pop_cnt++;
      fifo_empty = (fifo_q.size() == 0);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    mon_clear();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Streaming vectors: FIFO preloaded with 1..8, row k is cycle k after enable.
  typedef struct {
    logic             en;
    logic             rdy;
    logic             r_en;
    logic             bsy;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic [15:0]      bd;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    //            en rdy ren bsy vld data   lst bd
    tbl[0]  = '{1, 1, 0, 0, 0, 16'h0, 0, 16'd0};
    tbl[1]  = '{1, 1, 1, 1, 0, 16'h0, 0, 16'd0};
    tbl[2]  = '{1, 1, 1, 1, 0, 16'h0, 0, 16'd0};
    tbl[3]  = '{1, 1, 1, 1, 1, 16'h1, 0, 16'd0};
    tbl[4]  = '{1, 1, 1, 1, 1, 16'h2, 0, 16'd0};
    tbl[5]  = '{1, 1, 1, 1, 1, 16'h3, 0, 16'd0};
    tbl[6]  = '{1, 1, 1, 1, 1, 16'h4, 1, 16'd0};
    tbl[7]  = '{1, 1, 1, 1, 1, 16'h5, 0, 16'd1};
    tbl[8]  = '{1, 1, 1, 1, 1, 16'h6, 0, 16'd1};
    tbl[9]  = '{1, 1, 0, 1, 1, 16'h7, 0, 16'd1};
    tbl[10] = '{1, 1, 0, 1, 1, 16'h8, 1, 16'd1};
    tbl[11] = '{1, 1, 0, 1, 0, 16'h0, 0, 16'd2};
    mon_clear();

    // ---------------- reset state ----------------
    @(negedge clk);
    #1;
    check("rst_r_en",  32'(fifo_r_en),   32'd0);
    check("rst_valid", 32'(out_valid),   32'd0);
    check("rst_data",  32'(out_data),    32'd0);
    check("rst_last",  32'(out_last),    32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_bd",    32'(bursts_done), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rel_busy", 32'(busy),      32'd0);
    check("rel_r_en", 32'(fifo_r_en), 32'd0);
    tick();

    // ---------------- streaming (table) ----------------
    apply_reset();
    for (int i = 1; i <= 8; i++) push(WIDTH'(i));
    #1;
    check("idle_no_pop", 32'(fifo_r_en), 32'd0);
    tick();
    for (int k = 0; k < 12; k++) begin
      enable    = tbl[k].en;
      out_ready = tbl[k].rdy;
      #1;
      check($sformatf("str%0d_r_en", k),  32'(fifo_r_en),   32'(tbl[k].r_en));
      check($sformatf("str%0d_busy", k),  32'(busy),        32'(tbl[k].bsy));
      check($sformatf("str%0d_valid", k), 32'(out_valid),   32'(tbl[k].valid));
      check($sformatf("str%0d_last", k),  32'(out_last),    32'(tbl[k].last));
      check($sformatf("str%0d_bd", k),    32'(bursts_done), 32'(tbl[k].bd));
      if (tbl[k].valid) check($sformatf("str%0d_data", k), 32'(out_data), 32'(tbl[k].data));
      tick();
    end

    // ---------------- backpressure ----------------
    apply_reset();
    for (int i = 1; i <= 8; i++) push(WIDTH'(i));
    tick();
    for (int k = 0; k < 25; k++) begin
      enable    = 1'b1;
      out_ready = (k >= 9);
      #1;
      if (k >= 3 && k <= 8) begin
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data",  32'(out_data),  32'h1);
      end
      if (k >= 4 && k <= 9) check("bp_ren_low", 32'(fifo_r_en), 32'd0);
      if (k == 8)  check("bp_pops",   32'(pop_cnt),   32'd3);
      if (k == 10) check("bp_resume", 32'(fifo_r_en), 32'd1);
      tick();
    end
    check("bp_beats", 32'(beat_cnt), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < beat_data.size()) check("bp_order", 32'(beat_data[i]), 32'(i + 1));
    check("bp_bd", 32'(bursts_done), 32'd2);

    // ---------------- mid-burst underflow ----------------
    apply_reset();
    push(16'hA1);
    push(16'hA2);
    tick();
    for (int k = 0; k < 16; k++) begin
      enable    = 1'b1;
      out_ready = 1'b1;
      if (k == 7) begin
        push(16'hA3);
        push(16'hA4);
      end
      #1;
      if (k >= 3 && k <= 6) begin
        check("uf_ren_low", 32'(fifo_r_en), 32'd0);
        check("uf_busy",    32'(busy),      32'd1);
      end
      tick();
    end
    check("uf_beats", 32'(beat_cnt), 32'd4);
    if (beat_last.size() >= 4) begin
      check("uf_last_w2", 32'(beat_last[1]), 32'd0);
      check("uf_last_w4", 32'(beat_last[3]), 32'd1);
      check("uf_data_w4", 32'(beat_data[3]), 32'hA4);
    end

    // ---------------- enable drop mid-burst ----------------
    apply_reset();
    for (int i = 1; i <= 8; i++) push(WIDTH'(16'hB0 + i));
    tick();
    for (int k = 0; k < 14; k++) begin
      enable    = (k <= 2);
      out_ready = 1'b1;
      #1;
      if (k == 3 || k == 4) check("ed_pop", 32'(fifo_r_en), 32'd1);
      if (k == 5) check("ed_flush_no_pop", 32'(fifo_r_en), 32'd0);
      if (k == 7) check("ed_busy_flush",   32'(busy),      32'd1);
      if (k == 8) check("ed_busy_idle",    32'(busy),      32'd0);
      tick();
    end
    check("ed_pops",      32'(pop_cnt),       32'd4);
    check("ed_fifo_left", 32'(fifo_q.size()), 32'd4);
    check("ed_beats",     32'(beat_cnt),      32'd4);
    if (beat_last.size() >= 4) check("ed_last_w4", 32'(beat_last[3]), 32'd1);
    check("ed_bd", 32'(bursts_done), 32'd1);

    // ---------------- async reset with two words buffered ----------------
    apply_reset();
    for (int i = 1; i <= 8; i++) push(WIDTH'(16'hC0 + i));
    tick();
    for (int k = 0; k <= 4; k++) begin
      enable    = 1'b1;
      out_ready = 1'b0;
      #1;
      if (k == 4) begin
        check("ar_valid_before", 32'(out_valid), 32'd1);
        check("ar_pops_before",  32'(pop_cnt),   32'd3);
      end
      if (k < 4) tick();
    end
    #1;
    rst = 1'b0;
    mon_clear();
    #1;
    check("ar_valid", 32'(out_valid),   32'd0);
    check("ar_data",  32'(out_data),    32'd0);
    check("ar_last",  32'(out_last),    32'd0);
    check("ar_r_en",  32'(fifo_r_en),   32'd0);
    check("ar_busy",  32'(busy),        32'd0);
    check("ar_bd",    32'(bursts_done), 32'd0);
    tick();
    rst       = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    found     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("ar_resume_seen", 32'(found), 32'd1);
    if (found) check("ar_resume_word", 32'(out_data), 32'hC4);
    for (int c = 0; c < 8; c++) tick();

    // ---------------- randomized traffic ----------------
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 99) < 60) push(WIDTH'($urandom));
      enable    = (cyc < 700) ? ($urandom_range(0, 9) < 8) : 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      enable    = 1'b0;
      out_ready = 1'b1;
      if (fifo_q.size() < 2) push(WIDTH'($urandom));
      #1;
      if (!busy) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rnd_drained",     32'(found),          32'd1);
    check("rnd_burst_pops",  32'(pop_cnt % BL),   32'd0);
    check("rnd_all_out",     32'(beat_cnt),       32'(pop_cnt));
    check("rnd_sb_empty",    32'(sb_q.size()),    32'd0);
    check("rnd_bursts_done", 32'(bursts_done),    32'((beat_cnt / BL) & 16'hFFFF));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain stage that sits directly downstream of the team's synchronous FIFO. It pops words through the FIFO's `r_en`/`empty`/`dataout` port, absorbs the FIFO's one-cycle read latency, and re-times the words into a valid/ready stream through a 3-entry skid buffer. The stream is grouped into fixed-length bursts, with `out_last` marking the final word of each burst. The block sustains one word per cycle and never loses a word under downstream backpressure.

## Interface
- `WIDTH`, 16: data word width; must match the upstream FIFO width.
- `BURST_LEN`, 4: words per burst, ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `enable`  in  1  permission to start or continue bursts.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_en`  out  1  FIFO pop request.
- `fifo_dout`  in  WIDTH  FIFO read data, valid the cycle after an accepted pop.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  WIDTH  output word.
- `out_last`  out  1  last word of a burst; qualified by `out_valid`.
- `busy`  out  1  state ≠ IDLE.
- `bursts_done`  out  16  count of completed bursts; wraps.

## Operation
- **Accepted pop:** `fifo_r_en && !fifo_empty` in cycle t.
  - The FIFO presents the word on `fifo_dout` in cycle t+1.
  - The block writes it into the skid buffer at the end of t+1.
  - Set `inflight`=1 for cycle t+1.
- **Skid buffer:** 3-entry circular buffer with registered occupancy `occ` (0..3).
  - `out_valid` = (`occ`>0); `out_data` = head entry.
  - An output beat is `out_valid && out_ready`.
- **Pop gating:** `fifo_r_en` = (state = BURST) && !`fifo_empty` && (`occ` + `inflight` < 3).
  - The same-cycle output beat is not credited.
  - `fifo_r_en` is never high when `fifo_empty`=1.
- **FSM:**
  - IDLE: if `enable` && !`fifo_empty`, go to BURST with `pop_idx`=0.
  - BURST: each accepted pop increments `pop_idx`. On the pop with `pop_idx`=BURST_LEN-1:
    - `pop_idx` returns to 0.
    - If `enable`=1, stay in BURST (back-to-back bursts, no bubble).
    - If `enable`=0, go to FLUSH.
  - BURST: if `fifo_empty`=1 mid-burst, wait in BURST with no timeout.
  - BURST: if `enable` falls mid-burst, keep popping until the burst's BURST_LEN words are popped.
  - FLUSH: no pops. When `occ`=0 and `inflight`=0, go to IDLE.
- **Emission counter `out_idx`:**
  - Increments on each output beat, wrapping at BURST_LEN.
  - `out_last` = `out_valid` && (`out_idx` = BURST_LEN-1).
  - For BURST_LEN=1, `out_last` = `out_valid`.
- **`bursts_done`:** increments on each beat with `out_last`=1; wraps 0xFFFF→0.
- **Counter widths:** `pop_idx` and `out_idx` are max(1, clog2(BURST_LEN)) bits.
- **Simultaneous capture and output beat:** `occ` unchanged, head and tail both advance.

## Timing
- **Reset values** (asserted asynchronously, immediately): state IDLE, `occ`=0, `inflight`=0, `pop_idx`=0, `out_idx`=0.
  - Outputs: `fifo_r_en`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `bursts_done`=0.
- **Reset mid-operation:** buffered and in-flight words are discarded. The block does not reset the FIFO.
- **Start latency:** `enable` high in cycle e with `fifo_empty`=0 → BURST at e+1 → first pop at e+1 → `out_valid` at e+3.
  - Pop-to-output latency is 2 cycles.
- **Throughput:** with `out_ready` held high, one pop and one output beat per cycle.
- **Backpressure:** `out_ready` low → `occ` climbs to 3 max → `fifo_r_en` drops.
  - Once `out_ready` rises, popping resumes the cycle after `occ` + `inflight` falls below 3.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- **`busy`** falls the cycle after the FLUSH→IDLE condition is met.

## Test plan
- **Reset:** assert `rst`=0 mid-clock-period → all outputs reach their reset values before the next edge. Release → `busy`=0, `fifo_r_en`=0.
- **Streaming:** FIFO preloaded with 0x0001..0x0008, BURST_LEN=4, `out_ready`=1, `enable` held high →
  - 8 consecutive beats in order.
  - `out_last` on 0x0004 and 0x0008.
  - `bursts_done`=2.
  - First `out_valid` 3 cycles after `enable`.
- **Backpressure:** same preload, `out_ready`=0 for 6 cycles after the first `out_valid` →
  - Exactly 3 words are popped before `fifo_r_en` drops.
  - Order is preserved with no loss or duplication.
  - `out_data` is stable while stalled.
- **Mid-burst underflow:** FIFO holds 2 words, 2 more are written 5 cycles later →
  - Block stays in BURST with `fifo_r_en`=0 while empty.
  - No `out_last` on word 2.
  - `out_last` on word 4.
- **Enable drop mid-burst:** `enable` deasserted after pop 2 of a burst →
  - Pops 3 and 4 still occur.
  - FLUSH, then IDLE after the `out_last` beat.
  - No 5th pop.
- **Async reset with `out_valid`=1 and `occ`=2:** `out_valid` drops immediately. After release and re-enable, output resumes with the FIFO's next unread word.
